// File: rtl/inst_sram_axi_rd_bridge.sv
// Read-only bridge from the I-cache sram-like miss port to the AXI AR/R channels.
// It handles one single-beat read at a time. Defining INST_BRIDGE_RRESP_CHECK_EN adds an inst_err output.
module inst_sram_axi_rd_bridge #(
    parameter logic [3:0] AXI_ID = 4'd0,
    parameter int         ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [31:0]       inst_rdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
`ifdef INST_BRIDGE_RRESP_CHECK_EN
    output logic              inst_err,
`endif
    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic              arvalid,
    input  logic              arready,
    input  logic [3:0]        rid,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_AR   = 2'd1;
    localparam logic [1:0] S_R    = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              beat_ok;
    logic              unused_rresp;

    assign unused_rresp = ^rresp;
    assign beat_ok      = rvalid && (rid == AXI_ID);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (inst_req) begin
                    addr_d  = inst_addr;
                    // Size code 3 is not a legal access; it is narrowed to a word.
                    size_d  = (inst_size == 2'b11) ? 2'b10 : inst_size;
                    state_d = S_AR;
                end
            end
            S_AR: begin
                if (arready) state_d = S_R;
            end
            S_R: begin
                // A beat with a foreign ID is acked through rready and dropped here.
                if (beat_ok) begin
                    rdata_d = rdata;
                    if (rlast) begin
                        state_d = S_DONE;
`ifdef INST_BRIDGE_RRESP_CHECK_EN
                        err_d = rresp[1];
                        if (rresp[1]) rdata_d = 32'h0;
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            size_q  <= 2'b00;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Handshake outputs are gated by rst so that a reset silences them in the same cycle.
    assign inst_addr_ok = (state_q == S_IDLE) && inst_req && !rst;
    assign arvalid      = (state_q == S_AR)   && !rst;
    assign rready       = (state_q == S_R)    && !rst;
    assign inst_data_ok = (state_q == S_DONE) && !rst;
    assign inst_rdata   = rdata_q;
`ifdef INST_BRIDGE_RRESP_CHECK_EN
    assign inst_err     = inst_data_ok && err_q;
`endif

    assign arid   = AXI_ID;
    assign araddr = addr_q;
    assign arlen  = 8'd0;
    assign arsize = {1'b0, size_q};

endmodule

// File: doc/inst_sram_axi_rd_bridge.md
Name: inst_sram_axi_rd_bridge

Overview:
- Read-only bridge from the instruction cache's miss port (sram-like request/addr_ok/data_ok protocol) onto the AXI AR/R channels.
- Sits directly downstream of the instruction cache and upstream of the AXI crossbar/interconnect.
- One transaction in flight at a time, single-beat reads (arlen=0).
- Remaining AR attributes (burst, lock, cache, prot) are tied off at the top-level wrapper.

Parameters:
- AXI_ID, 4'd0, ID driven on arid; R beats are matched against it.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- inst_req  in  1  sram-like read request (held by cache until addr_ok)
- inst_size  in  2  access size code: 0=byte, 1=half, 2=word
- inst_addr  in  ADDR_W  request address
- inst_rdata  out  32  returned read data, valid with inst_data_ok
- inst_addr_ok  out  1  request accepted (1-cycle pulse)
- inst_data_ok  out  1  read data valid (1-cycle pulse)
- arid  out  4  = AXI_ID
- araddr  out  ADDR_W  latched request address
- arlen  out  8  constant 0
- arsize  out  3  {1'b0, latched size}
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rid  in  4  R ID
- rdata  in  32  R data
- rresp  in  2  R response
- rlast  in  1  R last
- rvalid  in  1  R valid
- rready  out  1  R ready

Behaviour:
- Reset rst, synchronous, active-high; clock clk.
- Reset values: arvalid=0, rready=0, inst_addr_ok=0, inst_data_ok=0, inst_rdata=0, araddr=0, arsize=0; state=IDLE.
- FSM states: IDLE, AR, R, DONE.
- IDLE:
  - inst_addr_ok = inst_req, combinational; all other outputs idle.
  - On inst_req, latch addr/size and go to AR.
  - inst_size=2'b11 is latched as 2'b10.
- AR:
  - arvalid=1; araddr/arsize come from the latched copies and are stable while arvalid is high.
  - On arvalid&arready, go to R. No further addr_ok is issued.
- R:
  - rready=1.
  - On rvalid with rid==AXI_ID: capture rdata into inst_rdata. If rlast, go to DONE.
  - A beat with rlast=0 (protocol anomaly) is captured and overwritten by later beats.
  - A beat with rid!=AXI_ID is accepted and discarded.
- DONE:
  - inst_data_ok=1 for exactly one cycle, then go to IDLE.
  - inst_rdata holds its value until the next capture.
- Latency:
  - Request accepted at cycle 0; arvalid high at cycle 1.
  - With arready high at cycle 1 and rvalid at cycle 2, inst_data_ok is high at cycle 3.
  - Minimum 3 cycles from request to data.
- inst_addr_ok is never asserted outside IDLE, so a new inst_req during AR/R/DONE waits. The earliest next acceptance is the cycle after DONE.
- rvalid in IDLE/AR/DONE is not acknowledged (rready=0).
- rst mid-transaction: return to IDLE on the next edge; arvalid and rready drop immediately; no data_ok is issued. Draining any in-flight AXI response is the interconnect's responsibility.
- Simultaneous inst_req and rst: rst wins; no addr_ok.

Optional Feature:
- Macro INST_BRIDGE_RRESP_CHECK_EN.
- Defined:
  - Extra port inst_err, out, 1.
  - On the accepted final beat, rresp[1]=1 (SLVERR/DECERR) sets inst_err high together with inst_data_ok for that one cycle; inst_rdata is forced to 32'h0.
  - inst_err resets to 0.
- Undefined: no inst_err port; rresp is ignored; data is passed regardless of response.

Test Plan:
- Basic read: inst_req=1, addr 0xBFC00000, size 2; arready=1 immediately; R beat rdata=0x3C1DBFC0 rlast=1 next cycle -> addr_ok at cycle 0, araddr=0xBFC00000, arsize=3'b010, arlen=0, inst_data_ok at cycle 3 with inst_rdata=0x3C1DBFC0.
- Backpressure: arready low for 4 cycles -> arvalid high and araddr stable for 5 cycles; no second addr_ok while inst_req stays high; data_ok one cycle after the rlast beat.
- Foreign ID: rid=4'd1 beat (rlast=1) followed by rid=AXI_ID beat 0x12345678 -> first beat discarded, inst_rdata=0x12345678, exactly one data_ok.
- Reset in R state: assert rst while waiting for rvalid -> next cycle arvalid=0, rready=0, no data_ok; a fresh request afterwards completes normally.
- Back-to-back: inst_req held high across two misses (0x100, 0x104) -> two addr_ok pulses separated by the full transaction; two data_ok pulses, in order.
- Error response (macro defined): rresp=2'b10 on the final beat -> inst_err=1 with inst_data_ok, inst_rdata=0; macro undefined -> data passed through.
